// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch + load/store) sharing
// a single memory request/response port. Only one transaction is outstanding
// at a time. It is granted in IDLE, presented to memory in ISSUE, and
// completed in WAIT, either by a memory response or by a forced timeout.
//
// Parameters
//   AW       address width
//   DW       data width (write mask is DW/8 bits)
//   TIMEOUT  WAIT cycles tolerated before forced completion (8-bit counter)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifu_req_valid/ready, ifu_addr, ifu_resp_valid, ifu_rdata
//                              read-only instruction-fetch requester
//   lsu_req_valid/ready, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
//   lsu_resp_valid, lsu_rdata  load/store requester
//   mem_req_valid/ready, mem_addr, mem_wen, mem_wdata, mem_wmask,
//   mem_resp_valid, mem_rdata  shared memory port
//   err_timeout                one-cycle pulse on forced completion
module mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  // instruction fetch port
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_resp_valid,
  output logic [DW-1:0]   ifu_rdata,
  // load/store port
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_resp_valid,
  output logic [DW-1:0]   lsu_rdata,
  // shared memory port
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err_timeout
);

  localparam int MW = DW / 8;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  // Owner / last-grant encoding: 0 = IFU, 1 = LSU.
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;

  logic            grant_ifu_s, grant_lsu_s;
  logic            ifu_rdy_s, lsu_rdy_s;
  logic            resp_s;
  logic [DW-1:0]   rdata_s;
  logic            err_s;
  logic            mem_req_valid_s;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    grant_ifu_s = ifu_req_valid & (~lsu_req_valid | (last_grant_q == OWN_LSU));
    grant_lsu_s = lsu_req_valid & (~ifu_req_valid | (last_grant_q == OWN_IFU));
  end

  // Next-state, payload capture and per-state outputs.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wdata_d         = wdata_q;
    wmask_d         = wmask_q;
    ifu_rdy_s       = 1'b0;
    lsu_rdy_s       = 1'b0;
    resp_s          = 1'b0;
    rdata_s         = '0;
    err_s           = 1'b0;
    mem_req_valid_s = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_ifu_s) begin
          ifu_rdy_s    = 1'b1;
          state_d      = ISSUE;
          owner_d      = OWN_IFU;
          last_grant_d = OWN_IFU;
          addr_d       = ifu_addr;
          // Fetches are always reads; clear the write payload explicitly.
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
        end else if (grant_lsu_s) begin
          lsu_rdy_s    = 1'b1;
          state_d      = ISSUE;
          owner_d      = OWN_LSU;
          last_grant_d = OWN_LSU;
          addr_d       = lsu_addr;
          wen_d        = lsu_wen;
          wdata_d      = lsu_wdata;
          wmask_d      = lsu_wmask;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        mem_req_valid_s = 1'b1;
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = 8'd0;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        // A real response wins over a timeout landing on the same cycle.
        if (mem_resp_valid) begin
          resp_s  = 1'b1;
          rdata_s = mem_rdata;
          state_d = IDLE;
        end else if (cnt_q == TMO) begin
          resp_s  = 1'b1;
          rdata_s = {DW{1'b1}};
          err_s   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched payload; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= OWN_LSU;
      owner_q      <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
    end
  end

  // Ready is gated by rst_n so nothing looks granted while reset is held.
  always_comb begin
    ifu_req_ready  = ifu_rdy_s & rst_n;
    lsu_req_ready  = lsu_rdy_s & rst_n;
    ifu_resp_valid = resp_s & (owner_q == OWN_IFU);
    lsu_resp_valid = resp_s & (owner_q == OWN_LSU);
    ifu_rdata      = (owner_q == OWN_IFU) ? rdata_s : '0;
    lsu_rdata      = (owner_q == OWN_LSU) ? rdata_s : '0;
    err_timeout    = err_s;
    mem_req_valid  = mem_req_valid_s;
    mem_addr       = addr_q;
    mem_wen        = wen_q;
    mem_wdata      = wdata_q;
    mem_wmask      = wmask_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for back-to-back grants, timeout, reset and
// spurious responses.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [63:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.AW(64), .DW(64), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic        lv;
    logic [63:0] ia;
    logic [63:0] la;
    logic        lw;
    logic [63:0] wd;
    logic [7:0]  wm;
    int          rdy;   // cycles mem_req_ready stays low
    int          resp;  // WAIT cycles before mem_resp_valid
    logic [63:0] rd;
    logic        own;   // expected winner: 0 IFU, 1 LSU
    logic [63:0] eaddr;
    logic        ewen;
    logic [63:0] ewd;
    logic [7:0]  ewm;
  } vec_t;

  vec_t vecs[6];

  // One transaction: request, issue with optional stall, wait, response.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    ifu_req_valid = v.iv; lsu_req_valid = v.lv;
    ifu_addr = v.ia; lsu_addr = v.la; lsu_wen = v.lw;
    lsu_wdata = v.wd; lsu_wmask = v.wm;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("ifu_ready", 64'(ifu_req_ready), 64'(v.own == 1'b0));
    chk("lsu_ready", 64'(lsu_req_ready), 64'(v.own == 1'b1));
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    ifu_addr = 64'h0; lsu_addr = 64'h0; lsu_wdata = 64'h0; lsu_wmask = 8'h00; lsu_wen = 1'b0;
    for (int k = 0; k <= v.rdy; k++) begin
      if (k > 0) @(negedge clk);
      mem_req_ready = (k == v.rdy);
      #1;
      chk("issue_valid", 64'(mem_req_valid), 64'h1);
      chk("mem_addr", mem_addr, v.eaddr);
      chk("mem_wen", 64'(mem_wen), 64'(v.ewen));
      chk("mem_wdata", mem_wdata, v.ewd);
      chk("mem_wmask", 64'(mem_wmask), 64'(v.ewm));
    end
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rdata = v.rd;
    for (int k = 0; k <= v.resp; k++) begin
      if (k > 0) @(negedge clk);
      mem_resp_valid = (k == v.resp);
      #1;
      chk("wait_req_valid", 64'(mem_req_valid), 64'h0);
      chk("ifu_resp", 64'(ifu_resp_valid), 64'((k == v.resp) && (v.own == 1'b0)));
      chk("lsu_resp", 64'(lsu_resp_valid), 64'((k == v.resp) && (v.own == 1'b1)));
      if (k == v.resp) begin
        chk("rdata", v.own ? lsu_rdata : ifu_rdata, v.rd);
        chk("resp_err", 64'(err_timeout), 64'h0);
      end
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    chk("post_resp", 64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'h0);
  endtask

  logic [4:0]  pat[6];
  logic        premature;
  vec_t        post;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 64'h80000000, 64'h0, 1'b1, 64'hdeadbeef00000000, 8'h0f,
                0, 0, 64'h00100093, 1'b0, 64'h80000000, 1'b0, 64'h0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 64'h80000040, 64'h80000100, 1'b0, 64'h5555, 8'h00,
                0, 1, 64'hcafef00d, 1'b1, 64'h80000100, 1'b0, 64'h5555, 8'h00};
    vecs[2] = '{1'b1, 1'b1, 64'h80000080, 64'h80000200, 1'b1, 64'h77, 8'h01,
                2, 0, 64'h0badc0de, 1'b0, 64'h80000080, 1'b0, 64'h0, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 64'h80000084, 64'h80001000, 1'b1, 64'h1122334455667788, 8'hff,
                3, 2, 64'h0, 1'b1, 64'h80001000, 1'b1, 64'h1122334455667788, 8'hff};
    vecs[4] = '{1'b0, 1'b1, 64'h0, 64'h80002008, 1'b0, 64'h0, 8'h00,
                0, 5, 64'h0123456789abcdef, 1'b1, 64'h80002008, 1'b0, 64'h0, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 64'h80000088, 64'h80003000, 1'b1, 64'haa, 8'h3c,
                1, 3, 64'hfedcba9876543210, 1'b0, 64'h80000088, 1'b0, 64'h0, 8'h00};
    // {ifu_ready, lsu_ready, mem_req_valid, ifu_resp, lsu_resp} per cycle
    pat[0] = 5'b10000; pat[1] = 5'b00100; pat[2] = 5'b00010;
    pat[3] = 5'b01000; pat[4] = 5'b00100; pat[5] = 5'b00001;

    // Reset held with busy-looking inputs: every output must be zero.
    rst_n = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 64'h80000000; lsu_addr = 64'h80000100;
    lsu_wen = 1'b1; lsu_wdata = 64'h1234; lsu_wmask = 8'hff;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h1234;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'({ifu_req_ready, lsu_req_ready}), 64'h0);
    chk("rst_resp", 64'({ifu_resp_valid, lsu_resp_valid, err_timeout}), 64'h0);
    chk("rst_mem_valid", 64'(mem_req_valid), 64'h0);
    chk("rst_payload", mem_addr | mem_wdata | 64'(mem_wmask) | 64'(mem_wen), 64'h0);

    // Release with both requesting and memory always ready/responding:
    // IFU, LSU, IFU, LSU at the minimum three-cycle spacing.
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk("b2b_pattern", 64'({ifu_req_ready, lsu_req_ready, mem_req_valid,
                              ifu_resp_valid, lsu_resp_valid}), 64'(pat[c % 6]));
    end
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Spurious response in IDLE changes nothing.
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 64'h5555aaaa;
    #1;
    chk("spur_resp", 64'({ifu_resp_valid, lsu_resp_valid, err_timeout, mem_req_valid}), 64'h0);
    @(negedge clk);
    #1;
    chk("spur_resp2", 64'({ifu_resp_valid, lsu_resp_valid, err_timeout, mem_req_valid}), 64'h0);
    chk("spur_addr", mem_addr, 64'h80000088);
    mem_resp_valid = 1'b0;

    // Request withdrawn before the clock edge: nothing latched.
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 64'h9000;
    #1;
    chk("drop_ready", 64'(lsu_req_ready), 64'h1);
    #2;
    lsu_req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("drop_no_issue", 64'(mem_req_valid), 64'h0);
    chk("drop_addr", mem_addr, 64'h80000088);

    // LSU read that never gets a response: forced completion.
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 64'h80005000; lsu_wen = 1'b0;
    #1;
    chk("tmo_grant", 64'(lsu_req_ready), 64'h1);
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    premature = 1'b0;
    for (int k = 0; k <= 255; k++) begin
      if (k > 0) @(negedge clk);
      ifu_req_valid = (k < 4);
      #1;
      if (k < 255) premature |= ifu_req_ready | lsu_resp_valid | ifu_resp_valid | err_timeout;
    end
    chk("tmo_early", 64'(premature), 64'h0);
    chk("tmo_resp", 64'(lsu_resp_valid), 64'h1);
    chk("tmo_rdata", lsu_rdata, 64'hffffffffffffffff);
    chk("tmo_err", 64'(err_timeout), 64'h1);
    chk("tmo_ifu_resp", 64'(ifu_resp_valid), 64'h0);
    @(negedge clk);
    #1;
    chk("tmo_err_pulse", 64'({err_timeout, lsu_resp_valid}), 64'h0);

    // Back in IDLE: IFU read whose response lands exactly on the timeout cycle.
    ifu_req_valid = 1'b1; ifu_addr = 64'h80006000;
    #1;
    chk("tmo_idle_ready", 64'(ifu_req_ready), 64'h1);
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rdata = 64'h5a5a5a5a5a5a5a5a;
    for (int k = 0; k <= 255; k++) begin
      if (k > 0) @(negedge clk);
      mem_resp_valid = (k == 255);
    end
    #1;
    chk("prec_resp", 64'(ifu_resp_valid), 64'h1);
    chk("prec_rdata", ifu_rdata, 64'h5a5a5a5a5a5a5a5a);
    chk("prec_err", 64'(err_timeout), 64'h0);
    @(negedge clk);
    mem_resp_valid = 1'b0;

    // Reset in the middle of WAIT; a late response must be ignored.
    lsu_req_valid = 1'b1; lsu_addr = 64'h80004000; lsu_wen = 1'b1;
    lsu_wdata = 64'h99; lsu_wmask = 8'h01;
    @(negedge clk);
    lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    chk("mid_rst_payload", mem_addr | mem_wdata | 64'(mem_wmask) | 64'(mem_wen), 64'h0);
    chk("mid_rst_ctrl", 64'({ifu_req_ready, lsu_req_ready, mem_req_valid,
                             ifu_resp_valid, lsu_resp_valid, err_timeout}), 64'h0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h77;
    #1;
    chk("late_resp", 64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'h0);
    @(negedge clk);
    #1;
    chk("late_resp2", 64'({ifu_resp_valid, lsu_resp_valid, mem_req_valid}), 64'h0);
    mem_resp_valid = 1'b0;

    // After reset the first tie goes to IFU.
    post = '{1'b1, 1'b1, 64'h80007000, 64'h80008000, 1'b1, 64'h42, 8'h80,
             0, 1, 64'h3131313131313131, 1'b0, 64'h80007000, 1'b0, 64'h0, 8'h00};
    run_vec(post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
